// File: rtl/particle_pkg.sv
// particle_pkg: shared types, box geometry and small helpers for the projectile flight.
package particle_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    FLY    = 3'd2,
    UPDATE = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    HIT_TARGET = 2'd1,
    HIT_CRATE  = 2'd2,
    MISS       = 2'd3
  } result_t;

  typedef struct packed {
    logic [11:0] x0;
    logic [11:0] y0;
    logic [11:0] x1;
    logic [11:0] y1;
  } box_t;

  // Shared with the drawing stages; edges are inclusive.
  localparam box_t CAT_BOX   = '{x0: 12'd60,  y0: 12'd560, x1: 12'd140, y1: 12'd690};
  localparam box_t DOG_BOX   = '{x0: 12'd860, y0: 12'd560, x1: 12'd940, y1: 12'd690};
  localparam box_t CRATE_BOX = '{x0: 12'd470, y0: 12'd520, x1: 12'd550, y1: 12'd690};

  function automatic logic in_box(input logic signed [12:0] x,
                                  input logic signed [12:0] y,
                                  input box_t b);
    return (x >= $signed({1'b0, b.x0})) && (x <= $signed({1'b0, b.x1})) &&
           (y >= $signed({1'b0, b.y0})) && (y <= $signed({1'b0, b.y1}));
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [8:0] v);
    if (v > 9'sd127)  return 8'sd127;
    if (v < -9'sd127) return -8'sd127;
    return v[7:0];
  endfunction

  function automatic logic [11:0] clamp12(input logic signed [12:0] v,
                                          input logic signed [12:0] hi);
    if (v < 13'sd0) return 12'd0;
    if (v > hi)     return hi[11:0];
    return v[11:0];
  endfunction

endpackage

// File: rtl/particle_collide.sv
// particle_collide: combinational classification of the particle position against
// the target box, the crate box and the screen/ground limits.
module particle_collide
  import particle_pkg::*;
#(
  parameter int GROUND_Y = 700,
  parameter int H_RES    = 1024
) (
  input  logic               turn,
  input  logic signed [12:0] x,
  input  logic signed [12:0] y,
  output logic               hit_target,
  output logic               hit_crate,
  output logic               miss
);

  localparam logic signed [12:0] Y_GROUND = 13'(GROUND_Y);
  localparam logic signed [12:0] X_LIMIT  = 13'(H_RES);

  always_comb begin
    hit_target = in_box(x, y, turn ? CAT_BOX : DOG_BOX);
    hit_crate  = in_box(x, y, CRATE_BOX);
    miss       = (y >= Y_GROUND) || (x < 13'sd0) || (x >= X_LIMIT);
  end

endmodule

// File: rtl/particle_flight_ctrl.sv
// particle_flight_ctrl: one projectile flight per turn, stepped once per frame tick.
// Optional build macro PARTICLE_TIMEOUT_EN ends a flight as MISS after 255 frames.
module particle_flight_ctrl
  import particle_pkg::*;
#(
  parameter int CAT_START_X = 100,
  parameter int DOG_START_X = 900,
  parameter int START_Y     = 500,
  parameter int GROUND_Y    = 700,
  parameter int H_RES       = 1024,
  parameter int GRAV_DIV    = 2,
  parameter int WIND_DIV    = 4
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        throw_flag,
  input  logic        turn,
  input  logic [4:0]  power,
  input  logic [2:0]  wind,
  input  logic        frame_tick,
  output logic [11:0] xpos_particle,
  output logic [11:0] ypos_particle,
  output logic        particle_active,
  output logic        end_throw,
  output logic [1:0]  result
);

  localparam logic signed [12:0] X_MAX = 13'(H_RES - 1);
  localparam logic signed [12:0] Y_MAX = 13'(GROUND_Y);

  state_t             state, state_next;
  logic               turn_q;
  logic [2:0]         wind_q;
  logic signed [12:0] pos_x, pos_y;
  logic signed [7:0]  vx, vy;
  logic [7:0]         frame_cnt;
  result_t            result_q;
  logic [11:0]        xpos_q, ypos_q;

  logic               hit_target, hit_crate, miss, timeout;
  result_t            outcome;
  logic signed [3:0]  wind_s;
  logic               grav_due, wind_due;
  logic signed [8:0]  vx_sum, vy_sum;
  logic signed [7:0]  power_s;

  particle_collide #(
    .GROUND_Y (GROUND_Y),
    .H_RES    (H_RES)
  ) u_collide (
    .turn       (turn_q),
    .x          (pos_x),
    .y          (pos_y),
    .hit_target (hit_target),
    .hit_crate  (hit_crate),
    .miss       (miss)
  );

`ifdef PARTICLE_TIMEOUT_EN
  assign timeout = (frame_cnt == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    outcome = NONE;
    if (hit_target)          outcome = HIT_TARGET;
    else if (hit_crate)      outcome = HIT_CRATE;
    else if (miss || timeout) outcome = MISS;
  end

  // Velocity steps are scheduled on the frame count before it advances.
  always_comb begin
    wind_s   = $signed({1'b0, wind_q}) - 4'sd4;
    grav_due = (int'(frame_cnt) % GRAV_DIV) == (GRAV_DIV - 1);
    wind_due = (int'(frame_cnt) % WIND_DIV) == (WIND_DIV - 1);
    vx_sum   = $signed({vx[7], vx}) +
               (wind_due ? $signed({{5{wind_s[3]}}, wind_s}) : 9'sd0);
    vy_sum   = $signed({vy[7], vy}) + (grav_due ? 9'sd1 : 9'sd0);
    power_s  = $signed({3'b000, power});
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    particle_active = 1'b0;
    end_throw       = 1'b0;
    unique case (state)
      IDLE:   if (throw_flag) state_next = LAUNCH;
      LAUNCH: state_next = FLY;
      FLY: begin
        particle_active = 1'b1;
        if (frame_tick) state_next = UPDATE;
      end
      UPDATE: begin
        particle_active = 1'b1;
        state_next      = CHECK;
      end
      CHECK: begin
        particle_active = 1'b1;
        state_next      = (outcome != NONE) ? DONE : FLY;
      end
      DONE: begin
        end_throw  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      turn_q    <= 1'b0;
      wind_q    <= 3'd0;
      pos_x     <= 13'(CAT_START_X);
      pos_y     <= 13'(START_Y);
      vx        <= 8'sd0;
      vy        <= 8'sd0;
      frame_cnt <= 8'd0;
      result_q  <= NONE;
    end else begin
      case (state)
        LAUNCH: begin
          turn_q    <= turn;
          wind_q    <= wind;
          vx        <= turn ? -power_s : power_s;
          vy        <= -power_s;
          pos_x     <= turn ? 13'(DOG_START_X) : 13'(CAT_START_X);
          pos_y     <= 13'(START_Y);
          frame_cnt <= 8'd0;
          result_q  <= NONE;
        end
        UPDATE: begin
          pos_x     <= pos_x + $signed({{5{vx[7]}}, vx});
          pos_y     <= pos_y + $signed({{5{vy[7]}}, vy});
          frame_cnt <= (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
          vx        <= sat8(vx_sum);
          vy        <= sat8(vy_sum);
        end
        CHECK: if (outcome != NONE) result_q <= outcome;
        default: ;
      endcase
    end
  end

  // Before a flight is under way the outputs show the current thrower's launch point.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      xpos_q <= 12'(CAT_START_X);
      ypos_q <= 12'(START_Y);
    end else if (state == IDLE || state == LAUNCH) begin
      xpos_q <= turn ? 12'(DOG_START_X) : 12'(CAT_START_X);
      ypos_q <= 12'(START_Y);
    end else begin
      xpos_q <= clamp12(pos_x, X_MAX);
      ypos_q <= clamp12(pos_y, Y_MAX);
    end
  end

  assign xpos_particle = xpos_q;
  assign ypos_particle = ypos_q;
  assign result        = result_q;

endmodule

// File: tb/tb_particle_flight_ctrl.sv
// Self-checking bench for particle_flight_ctrl: directed flight table, corner sequences
// and randomized flights compared against a frame-level trajectory model.
`timescale 1ns/1ps
module tb_particle_flight_ctrl;

  logic        clk60MHz = 1'b0;
  logic        rst = 1'b1;
  logic        throw_flag = 1'b0;
  logic        turn = 1'b0;
  logic [4:0]  power = 5'd0;
  logic [2:0]  wind = 3'd4;
  logic        frame_tick = 1'b0;
  logic [11:0] xpos_particle, ypos_particle;
  logic        particle_active, end_throw;
  logic [1:0]  result;

  always #8 clk60MHz = ~clk60MHz;

  particle_flight_ctrl dut (
    .clk60MHz        (clk60MHz),
    .rst             (rst),
    .throw_flag      (throw_flag),
    .turn            (turn),
    .power           (power),
    .wind            (wind),
    .frame_tick      (frame_tick),
    .xpos_particle   (xpos_particle),
    .ypos_particle   (ypos_particle),
    .particle_active (particle_active),
    .end_throw       (end_throw),
    .result          (result)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int end_count = 0;

  always @(negedge clk60MHz) if (end_throw) end_count <= end_count + 1;

  // Frame-level trajectory model
  int m_x, m_y, m_vx, m_vy, m_n, m_w;
  bit m_turn;

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic int clampv(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic bit inside_box(input int x, input int y, input int x0, input int y0,
                                    input int x1, input int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  function automatic int model_outcome();
    bit tgt;
    tgt = m_turn ? inside_box(m_x, m_y, 60, 560, 140, 690)
                 : inside_box(m_x, m_y, 860, 560, 940, 690);
    if (tgt) return 1;
    if (inside_box(m_x, m_y, 470, 520, 550, 690)) return 2;
    if (m_y >= 700 || m_x < 0 || m_x >= 1024) return 3;
    return 0;
  endfunction

  task automatic model_launch(input bit t, input int p, input int w);
    m_turn = t;
    m_x    = t ? 900 : 100;
    m_y    = 500;
    m_vx   = t ? -p : p;
    m_vy   = -p;
    m_n    = 0;
    m_w    = w - 4;
  endtask

  task automatic model_step();
    m_x = m_x + m_vx;
    m_y = m_y + m_vy;
    if (m_n % 2 == 1) m_vy = sat(m_vy + 1);
    if (m_n % 4 == 3) m_vx = sat(m_vx + m_w);
    if (m_n < 255) m_n = m_n + 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_launch(input bit t, input int p, input int w);
    turn  = t;
    power = 5'(p);
    wind  = 3'(w);
    @(posedge clk60MHz); #1 throw_flag = 1'b1;
    @(posedge clk60MHz); #1 throw_flag = 1'b0;
    @(negedge clk60MHz);
    check("active_one_cycle_after_throw", int'(particle_active), 0);
    @(negedge clk60MHz);
    check("active_two_cycles_after_throw", int'(particle_active), 1);
    check("launch_x", int'(xpos_particle), t ? 900 : 100);
    check("launch_y", int'(ypos_particle), 500);
    model_launch(t, p, w);
  endtask

  // Entered at a negedge with the DUT in flight; leaves at the negedge after outputs move.
  task automatic tick_and_sample();
    @(posedge clk60MHz); #1 frame_tick = 1'b1;
    @(posedge clk60MHz); #1 frame_tick = 1'b0;
    @(posedge clk60MHz);
    @(posedge clk60MHz);
    @(negedge clk60MHz);
  endtask

  task automatic fly_to_end(input int throw_at, output int res, output int fx, output int fy);
    int oc;
    bit done;
    done = 1'b0;
    res = 0; fx = 0; fy = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk60MHz);
      if (k == throw_at) begin
        @(posedge clk60MHz); #1 throw_flag = 1'b1;
        @(posedge clk60MHz); #1 throw_flag = 1'b0;
        @(negedge clk60MHz);
      end
      tick_and_sample();
      model_step();
      oc = model_outcome();
      check("xpos", int'(xpos_particle), clampv(m_x, 1023));
      check("ypos", int'(ypos_particle), clampv(m_y, 700));
      check("end_throw", int'(end_throw), int'(oc != 0));
      if (oc != 0) begin
        check("result_at_end", int'(result), oc);
        res  = int'(result);
        fx   = int'(xpos_particle);
        fy   = int'(ypos_particle);
        done = 1'b1;
      end
    end
    if (!done) check("flight_frame_bound", 0, 1);
    @(negedge clk60MHz);
    check("end_throw_single_pulse", int'(end_throw), 0);
    check("active_after_end", int'(particle_active), 0);
    check("result_held", int'(result), res);
  endtask

  typedef struct {
    bit t;
    int p;
    int w;
    int exp_res;
    int exp_x;
    int exp_y;
  } vec_t;

  vec_t vecs[4];
  int   res, fx, fy, snap;
  bit   rt;
  int   rp, rw;

  initial begin
    vecs[0] = '{t: 1'b0, p: 0,  w: 4, exp_res: 3, exp_x: 100, exp_y: 700};
    vecs[1] = '{t: 1'b1, p: 31, w: 0, exp_res: 3, exp_x: 0,   exp_y: 0};
    vecs[2] = '{t: 1'b0, p: 10, w: 4, exp_res: 2, exp_x: 540, exp_y: 522};
    vecs[3] = '{t: 1'b0, p: 13, w: 4, exp_res: 1, exp_x: 867, exp_y: 574};

    // Reset and idle tracking
    rst = 1'b1; turn = 1'b1;
    repeat (3) @(posedge clk60MHz);
    @(negedge clk60MHz);
    check("reset_x", int'(xpos_particle), 100);
    check("reset_y", int'(ypos_particle), 500);
    check("reset_active", int'(particle_active), 0);
    check("reset_end_throw", int'(end_throw), 0);
    check("reset_result", int'(result), 0);
    @(posedge clk60MHz); #1 rst = 1'b0;
    repeat (2) @(negedge clk60MHz);
    check("idle_dog_x", int'(xpos_particle), 900);
    check("idle_dog_y", int'(ypos_particle), 500);
    check("idle_active", int'(particle_active), 0);
    check("idle_result", int'(result), 0);

    // First frames, then a crate hit with an ignored mid-flight throw
    snap = end_count;
    do_launch(1'b0, 10, 4);
    tick_and_sample(); model_step();
    check("tick1_x", int'(xpos_particle), 110);
    check("tick1_y", int'(ypos_particle), 490);
    tick_and_sample(); model_step();
    check("tick2_x", int'(xpos_particle), 120);
    check("tick2_y", int'(ypos_particle), 480);
    fly_to_end(3, res, fx, fy);
    check("crate_result", res, 2);
    check("crate_x", fx, 540);
    check("crate_y", fy, 522);
    @(negedge clk60MHz);
    check("crate_end_pulses", end_count - snap, 1);

    // Directed flight table
    for (int i = 0; i < 4; i++) begin
      do_launch(vecs[i].t, vecs[i].p, vecs[i].w);
      fly_to_end(-1, res, fx, fy);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_x", i), fx, vecs[i].exp_x);
      check($sformatf("vec%0d_y", i), fy, vecs[i].exp_y);
    end

    // Tick arriving during CHECK is dropped
    do_launch(1'b0, 12, 4);
    tick_and_sample(); model_step();
    check("drop_pre_x", int'(xpos_particle), clampv(m_x, 1023));
    @(posedge clk60MHz); #1 frame_tick = 1'b1;
    @(posedge clk60MHz); #1 frame_tick = 1'b0;
    @(posedge clk60MHz); #1 frame_tick = 1'b1;
    @(posedge clk60MHz); #1 frame_tick = 1'b0;
    model_step();
    repeat (4) @(negedge clk60MHz);
    check("drop_x", int'(xpos_particle), clampv(m_x, 1023));
    check("drop_y", int'(ypos_particle), clampv(m_y, 700));
    check("drop_active", int'(particle_active), 1);

    // Reset in the middle of a frame update
    snap = end_count;
    @(posedge clk60MHz); #1 frame_tick = 1'b1;
    @(posedge clk60MHz); #1 begin frame_tick = 1'b0; rst = 1'b1; end
    @(posedge clk60MHz); #1 rst = 1'b0;
    @(negedge clk60MHz);
    check("midrst_active", int'(particle_active), 0);
    check("midrst_end_throw", int'(end_throw), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_x", int'(xpos_particle), 100);
    check("midrst_y", int'(ypos_particle), 500);
    repeat (4) @(negedge clk60MHz);
    check("midrst_no_end_pulse", end_count - snap, 0);
    check("midrst_idle_active", int'(particle_active), 0);

    // Randomized flights
    for (int i = 0; i < 20; i++) begin
      rt = 1'($urandom_range(0, 1));
      rp = int'($urandom_range(0, 31));
      rw = int'($urandom_range(0, 7));
      do_launch(rt, rp, rw);
      fly_to_end(-1, res, fx, fy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
